// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: data widths, RV32I funct3 codes,
// FSM state encoding and the request legality/alignment check.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NBYTES = XLEN / 8;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // True when the request is an illegal funct3 for its direction or misaligned.
    // Unsigned loads share their size with the signed codes, so stores reject them.
    function automatic logic is_fault(input logic store, input logic [2:0] funct3,
                                      input logic [1:0] off);
        logic f;
        case (funct3)
            F3_LB:   f = 1'b0;
            F3_LH:   f = off[0];
            F3_LW:   f = (off != 2'b00);
            F3_LBU:  f = store;
            F3_LHU:  f = store | off[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response and memory bus bundle for the load/store unit.
//   master : requester/memory side (drives req_*, mem_rdata)
//   slave  : the load/store unit  (drives req_ready, resp_*, mem_* outputs)
interface load_store_unit_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_fault;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [NBYTES-1:0] mem_wmask;
    logic              mem_rstrb;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               mem_addr, mem_wdata, mem_wmask, mem_rstrb
    );

endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed bytes of a memory word down to
// bit 0 and sign/zero-extends according to funct3.
//   funct3   : load size/sign code
//   byte_off : address bits [1:0]
//   word     : raw memory read word
//   data_c   : aligned, extended result (combinational)
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = word >> {byte_off, 3'b000};
        case (funct3)
            F3_LB:   data_c = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data_c = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data_c = {24'h0, shifted[7:0]};
            F3_LHU:  data_c = {16'h0, shifted[15:0]};
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time, issues a single
// aligned memory access and returns a one-cycle response.
//   clk, reset : clock and synchronous active-high reset
//   bus        : core request/response and memory bus (slave side)
module load_store_unit
    import lsu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus
);

    lsu_state_e        state_q, state_d;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        off_q;
    logic              xfer_c;
    logic              fault_c;
    logic [XLEN-1:0]   st_wdata_c;
    logic [NBYTES-1:0] st_wmask_c;
    logic [XLEN-1:0]   ld_data_c;

    assign xfer_c  = bus.req_valid && (state_q == ST_IDLE);
    assign fault_c = is_fault(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);

    // Store lane replication and byte enables from the incoming request.
    always_comb begin
        st_wdata_c = bus.req_wdata;
        st_wmask_c = {NBYTES{1'b1}};
        case (bus.req_funct3)
            F3_SB: begin
                st_wdata_c = {4{bus.req_wdata[7:0]}};
                st_wmask_c = 4'b0001 << bus.req_addr[1:0];
            end
            F3_SH: begin
                st_wdata_c = {2{bus.req_wdata[15:0]}};
                st_wmask_c = 4'b0011 << {bus.req_addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (xfer_c) state_d = fault_c ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_d = store_q ? ST_RESP : ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    lsu_load_align u_align (
        .funct3   (funct3_q),
        .byte_off (off_q),
        .word     (bus.mem_rdata),
        .data_c   (ld_data_c)
    );

    // Registered outputs; memory strobes are armed on the accept edge so they
    // are high during the ISSUE cycle only.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_fault <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.mem_wmask  <= '0;
            bus.mem_rstrb  <= 1'b0;
            store_q        <= 1'b0;
            funct3_q       <= 3'b000;
            off_q          <= 2'b00;
        end else begin
            bus.req_ready  <= (state_d == ST_IDLE);
            bus.resp_valid <= (state_d == ST_RESP);
            bus.resp_fault <= 1'b0;
            bus.mem_wmask  <= '0;
            bus.mem_rstrb  <= 1'b0;
            if (xfer_c) begin
                store_q  <= bus.req_store;
                funct3_q <= bus.req_funct3;
                off_q    <= bus.req_addr[1:0];
                if (fault_c) begin
                    bus.resp_fault <= 1'b1;
                end else begin
                    bus.mem_addr <= {bus.req_addr[XLEN-1:2], 2'b00};
                    if (bus.req_store) begin
                        bus.mem_wdata <= st_wdata_c;
                        bus.mem_wmask <= st_wmask_c;
                    end else begin
                        bus.mem_rstrb <= 1'b1;
                    end
                end
            end
            if (state_q == ST_WAIT) bus.resp_rdata <= ld_data_c;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array memory behind the bus,
// a reference memory for expected load data, and queues of expected memory
// issues and responses checked on the falling edge.
module tb_load_store_unit;

    logic clk;
    logic reset;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        time         t0;
    } resp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        rstrb;
    } issue_exp_t;

    resp_exp_t  resp_q[$];
    issue_exp_t issue_q[$];

    logic [7:0]  tb_mem  [1024];
    logic [7:0]  ref_mem [1024];
    logic [31:0] last_rdata;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Memory model: writes on the edge ending ISSUE, read data valid next cycle.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) tb_mem[{bus.mem_addr[9:2], 2'(b)}] <= bus.mem_wdata[8*b +: 8];
        if (bus.mem_rstrb)
            bus.mem_rdata <= {tb_mem[{bus.mem_addr[9:2], 2'd3}], tb_mem[{bus.mem_addr[9:2], 2'd2}],
                              tb_mem[{bus.mem_addr[9:2], 2'd1}], tb_mem[{bus.mem_addr[9:2], 2'd0}]};
    end

    // Issue monitor: any strobe must match the oldest expected access.
    always @(negedge clk) begin
        issue_exp_t e;
        if (bus.mem_rstrb || (bus.mem_wmask != 4'b0000)) begin
            if (issue_q.size() == 0) begin
                check("unexpected_issue", 32'(bus.mem_wmask) | (32'(bus.mem_rstrb) << 4), 32'd0);
            end else begin
                e = issue_q.pop_front();
                check("mem_addr", bus.mem_addr, e.addr);
                check("mem_wmask", 32'(bus.mem_wmask), 32'(e.wmask));
                check("mem_rstrb", 32'(bus.mem_rstrb), 32'(e.rstrb));
                if (!e.rstrb) check("mem_wdata", bus.mem_wdata, e.wdata);
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        resp_exp_t e;
        if (bus.resp_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                e = resp_q.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
                check("resp_latency", 32'(int'(($time - e.t0 + 5) / 10)), 32'(e.lat));
                check("ready_in_resp", 32'(bus.req_ready), 32'd0);
            end
        end else if (bus.resp_fault) begin
            check("stray_fault", 32'(bus.resp_fault), 32'd0);
        end
    end

    // Present one request when the unit is ready; push its expectations.
    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] d);
        resp_exp_t  r;
        issue_exp_t is;
        int nb, off, guard;
        logic legal;
        logic [31:0] v;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            check("ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        r.fault = !legal || ((off % nb) != 0);
        r.t0    = $time + 5;
        is.addr  = {addr[31:2], 2'b00};
        is.wdata = 32'h0;
        is.wmask = 4'b0000;
        if (r.fault) begin
            r.rdata = last_rdata;
            r.lat   = 1;
        end else if (st) begin
            is.rstrb = 1'b0;
            for (int b = 0; b < 4; b++) begin
                is.wdata[8*b +: 8] = d[8*(b % nb) +: 8];
                if (b >= off && b < off + nb) begin
                    is.wmask[b] = 1'b1;
                    ref_mem[{addr[9:2], 2'(b)}] = d[8*(b - off) +: 8];
                end
            end
            issue_q.push_back(is);
            r.rdata = last_rdata;
            r.lat   = 2;
        end else begin
            is.rstrb = 1'b1;
            issue_q.push_back(is);
            v = 32'h0;
            for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[{addr[9:2], 2'(off + k)}];
            if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
            last_rdata = v;
            r.rdata = v;
            r.lat   = 3;
        end
        resp_q.push_back(r);
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = d;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (resp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (resp_q.size() != 0) check("drain_timeout", 32'(resp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] v8;
        n_cmp = 0;
        n_bad = 0;
        last_rdata = 32'h0;
        reset = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            v8 = 8'($urandom);
            tb_mem[i]  = v8;
            ref_mem[i] = v8;
        end

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        check("rst_mem_rstrb", 32'(bus.mem_rstrb), 32'd0);
        reset = 1'b0;

        // Directed cases: word, byte and halfword round trips, then faults.
        drive(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        drive(1'b0, 3'b010, 32'h100, 32'h0);
        drive(1'b1, 3'b000, 32'h103, 32'h000000A5);
        drive(1'b0, 3'b000, 32'h103, 32'h0);
        drive(1'b0, 3'b100, 32'h103, 32'h0);
        drive(1'b1, 3'b001, 32'h102, 32'h00008001);
        drive(1'b0, 3'b001, 32'h102, 32'h0);
        drive(1'b0, 3'b101, 32'h102, 32'h0);
        drive(1'b0, 3'b010, 32'h101, 32'h0);
        drive(1'b1, 3'b001, 32'h103, 32'h12345678);
        drive(1'b0, 3'b011, 32'h100, 32'h0);
        drive(1'b1, 3'b100, 32'h104, 32'h0);
        wait_done();

        // Reset while the load sits in WAIT aborts it silently.
        drive(1'b0, 3'b010, 32'h100, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_resp_rdata", bus.resp_rdata, 32'd0);
        resp_q.delete();
        last_rdata = 32'h0;
        drive(1'b0, 3'b010, 32'h100, 32'h0);
        wait_done();

        // Random mix over a small window so loads hit earlier stores.
        for (int i = 0; i < 40; i++)
            drive(1'($urandom), 3'($urandom_range(0, 7)), 32'h100 + 32'($urandom_range(0, 63)),
                  $urandom);
        wait_done();
        check("issue_queue_empty", 32'(issue_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
